capture_window_ctrl: RTL and testbench

- Sits directly downstream of the capture channel mapper.
- Consumes its packed sample words (in_valid/in_data), its trigger flag and its trigger sub-position.
- Stores words in an internal circular RAM and enforces a pre-trigger/post-trigger capture window.
- Latches trigger location, then streams the captured window out oldest-first over a valid/ready read port to the host-transfer logic.

---
 rtl/capture_window_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_capture_window_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_window_ctrl.sv
// -----------------------------------------------------------------------------
// capture_window_ctrl
//
// Capture-window controller placed after the capture channel mapper. Incoming
// sample words are written into a circular RAM. The controller keeps a
// configurable number of words before and after the trigger word, latches the
// trigger location, and then streams the captured window out oldest-first over
// a valid/ready read port.
//
// Parameters
//   ADDR_W  log2 of the buffer depth in words (depth = 2**ADDR_W)
//   DATA_W  sample word width
//
// Ports
//   clk_i              capture clock
//   rst_i              synchronous active-high reset
//   arm_i              pulse: latch window config and start a new capture
//   pre_words_i        words to keep before the trigger word
//   post_words_i       words to keep after the trigger word
//   in_valid_i         in_data_i holds a complete word this cycle
//   in_data_i          packed sample word
//   in_triggered_i     trigger fell inside the word presented with in_valid_i
//   in_trig_sample_i   trigger sub-word position
//   state_o            current FSM state (IDLE=0 .. READ=5)
//   done_o             capture complete, buffer readable
//   trig_addr_o        RAM address of the trigger word
//   trig_sample_out_o  latched trigger sub-word position
//   capt_len_o         words in the captured window
//   rd_start_i         pulse: begin readout (honoured in DONE only)
//   rd_valid_o         rd_data_o valid
//   rd_ready_i         consumer accepts rd_data_o
//   rd_data_o          buffered word
//   rd_last_o          final word of the window
//   word_cnt_o         accepted writes since arm
//
// Build options
//   CAPTURE_WORD_CNT_EN  when defined, word_cnt_o is a saturating count of
//                        accepted writes since arm; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module capture_window_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic [ADDR_W-1:0] pre_words_i,
  input  logic [ADDR_W-1:0] post_words_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_triggered_i,
  input  logic [7:0]        in_trig_sample_i,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic [7:0]        trig_sample_out_o,
  output logic [ADDR_W:0]   capt_len_o,
  input  logic              rd_start_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic [31:0]       word_cnt_o
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LenOne  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPretrig  = 3'd1,
    StWaitTrig = 3'd2,
    StPosttrig = 3'd3,
    StDone     = 3'd4,
    StRead     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_eff_q, pre_eff_d;
  logic [ADDR_W-1:0] post_eff_q, post_eff_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [7:0]        trig_sample_q, trig_sample_d;
  logic [ADDR_W:0]   capt_len_q, capt_len_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   rd_rem_q, rd_rem_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem_q [Depth];

  logic              capturing;
  logic              wr_en;
  logic              rd_xfer;
  logic              rd_fetch;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] pre_room;
  logic [ADDR_W-1:0] cfg_pre_eff;
  logic [ADDR_W:0]   cfg_capt_len;

  // post_words_i cannot exceed depth-1 by width, so it is used as-is. The
  // pre-trigger share is clipped to what is left after the post window and
  // the trigger word itself: depth-1-post is simply the bitwise complement.
  always_comb begin
    pre_room     = ~post_words_i;
    cfg_pre_eff  = (pre_words_i > pre_room) ? pre_room : pre_words_i;
    cfg_capt_len = {1'b0, cfg_pre_eff} + {1'b0, post_words_i} + LenOne;
  end

  always_comb begin
    capturing = (state_q == StPretrig) || (state_q == StWaitTrig) ||
                (state_q == StPosttrig);
    // arm wins over a coincident word; that word is dropped
    wr_en     = capturing && in_valid_i && !arm_i;
    rd_xfer   = rd_valid_q && rd_ready_i;
    // The read register doubles as the output stage: a new word is fetched
    // whenever it is empty or being drained, giving one word per cycle.
    rd_fetch  = !arm_i &&
                (((state_q == StDone) && rd_start_i) ||
                 ((state_q == StRead) && (rd_rem_q != '0) && (!rd_valid_q || rd_ready_i)));
    rd_addr   = (state_q == StDone) ? (trig_addr_q - pre_eff_q) : rd_ptr_q;
  end

  // Next-state and datapath control
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    pre_eff_d     = pre_eff_q;
    post_eff_d    = post_eff_q;
    trig_addr_d   = trig_addr_q;
    trig_sample_d = trig_sample_q;
    capt_len_d    = capt_len_q;
    done_d        = done_q;
    rd_ptr_d      = rd_ptr_q;
    rd_rem_d      = rd_rem_q;
    rd_valid_d    = rd_valid_q;
    rd_last_d     = rd_last_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AddrOne;
    end

    unique case (state_q)
      StPretrig: begin
        // Triggers are ignored until the pre-trigger history is filled
        if (wr_en) begin
          cnt_d = cnt_q - AddrOne;
          if (cnt_q == AddrOne) begin
            state_d = StWaitTrig;
          end
        end
      end
      StWaitTrig: begin
        if (wr_en && in_triggered_i) begin
          trig_addr_d   = wr_ptr_q;
          trig_sample_d = in_trig_sample_i;
          cnt_d         = post_eff_q;
          if (post_eff_q == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StPosttrig;
          end
        end
      end
      StPosttrig: begin
        if (wr_en) begin
          cnt_d = cnt_q - AddrOne;
          if (cnt_q == AddrOne) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        if (rd_start_i) begin
          // First word is fetched on this edge so rd_valid rises next cycle
          state_d    = StRead;
          rd_ptr_d   = rd_addr + AddrOne;
          rd_rem_d   = capt_len_q - LenOne;
          rd_valid_d = 1'b1;
          rd_last_d  = (capt_len_q == LenOne);
        end
      end
      StRead: begin
        if (rd_fetch) begin
          rd_ptr_d   = rd_ptr_q + AddrOne;
          rd_rem_d   = rd_rem_q - LenOne;
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_rem_q == LenOne);
        end else if (rd_xfer) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            state_d = StDone;
          end
        end
      end
      default: begin
        // StIdle: wait for arm
      end
    endcase

    if (arm_i) begin
      done_d        = 1'b0;
      trig_addr_d   = '0;
      trig_sample_d = '0;
      wr_ptr_d      = '0;
      pre_eff_d     = cfg_pre_eff;
      post_eff_d    = post_words_i;
      capt_len_d    = cfg_capt_len;
      cnt_d         = cfg_pre_eff;
      rd_ptr_d      = '0;
      rd_rem_d      = '0;
      rd_valid_d    = 1'b0;
      rd_last_d     = 1'b0;
      state_d       = (cfg_pre_eff == '0) ? StWaitTrig : StPretrig;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      pre_eff_q     <= '0;
      post_eff_q    <= '0;
      trig_addr_q   <= '0;
      trig_sample_q <= '0;
      capt_len_q    <= '0;
      done_q        <= 1'b0;
      rd_ptr_q      <= '0;
      rd_rem_q      <= '0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      pre_eff_q     <= pre_eff_d;
      post_eff_q    <= post_eff_d;
      trig_addr_q   <= trig_addr_d;
      trig_sample_q <= trig_sample_d;
      capt_len_q    <= capt_len_d;
      done_q        <= done_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_rem_q      <= rd_rem_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
    end
  end

  // Sample RAM: contents are never reset
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_fetch) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

`ifdef CAPTURE_WORD_CNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || arm_i) begin
      word_cnt_q <= '0;
    end else if (wr_en && (word_cnt_q != '1)) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign word_cnt_o = word_cnt_q;
`else
  assign word_cnt_o = '0;
`endif

  assign state_o           = state_q;
  assign done_o            = done_q;
  assign trig_addr_o       = trig_addr_q;
  assign trig_sample_out_o = trig_sample_q;
  assign capt_len_o        = capt_len_q;
  assign rd_valid_o        = rd_valid_q;
  assign rd_data_o         = rd_data_q;
  assign rd_last_o         = rd_last_q;

endmodule

// File: tb/tb_capture_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_window_ctrl
//
// Self-checking bench for capture_window_ctrl (ADDR_W=4, DATA_W=32). A
// behavioural model keeps the list of accepted words since arm and the index
// of the accepted trigger word; expected window contents, trigger address and
// status are derived from that list.
// -----------------------------------------------------------------------------
module tb_capture_window_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int          D  = 16;

  logic          clk;
  logic          rst;
  logic          arm;
  logic [AW-1:0] pre_words;
  logic [AW-1:0] post_words;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_triggered;
  logic [7:0]    in_trig_sample;
  logic [2:0]    state;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [7:0]    trig_sample_out;
  logic [AW:0]   capt_len;
  logic          rd_start;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [31:0]   word_cnt;

  capture_window_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .arm_i            (arm),
    .pre_words_i      (pre_words),
    .post_words_i     (post_words),
    .in_valid_i       (in_valid),
    .in_data_i        (in_data),
    .in_triggered_i   (in_triggered),
    .in_trig_sample_i (in_trig_sample),
    .state_o          (state),
    .done_o           (done),
    .trig_addr_o      (trig_addr),
    .trig_sample_out_o(trig_sample_out),
    .capt_len_o       (capt_len),
    .rd_start_i       (rd_start),
    .rd_valid_o       (rd_valid),
    .rd_ready_i       (rd_ready),
    .rd_data_o        (rd_data),
    .rd_last_o        (rd_last),
    .word_cnt_o       (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words accepted since arm, trigger index into that list
  logic [DW-1:0] hist[$];
  int            trig_idx = -1;
  int            m_pre    = 0;
  int            m_post   = 0;
  bit            m_armed  = 1'b0;
  logic [7:0]    m_tsample = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_done();
    return (trig_idx >= 0) && (hist.size() == trig_idx + m_post + 1);
  endfunction

  function automatic int m_state();
    if (!m_armed) return 0;
    if (m_done()) return 4;
    if (trig_idx < 0) return (hist.size() < m_pre) ? 1 : 2;
    return 3;
  endfunction

  function automatic int m_word_cnt();
`ifdef CAPTURE_WORD_CNT_EN
    return hist.size();
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    trig_idx  = -1;
    m_armed   = 1'b0;
    m_tsample = 8'h00;
    m_pre     = 0;
    m_post    = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, " state"}, 64'(state), 64'(m_state()));
    check({tag, " done"}, 64'(done), 64'(m_done()));
    check({tag, " trig_addr"}, 64'(trig_addr), 64'((trig_idx >= 0) ? (trig_idx % D) : 0));
    check({tag, " trig_sample"}, 64'(trig_sample_out), 64'((trig_idx >= 0) ? m_tsample : 8'h00));
    check({tag, " word_cnt"}, 64'(word_cnt), 64'(m_word_cnt()));
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic do_arm(input int pre, input int post, input bit with_valid);
    arm          = 1'b1;
    pre_words    = AW'(pre);
    post_words   = AW'(post);
    in_valid     = with_valid;
    in_data      = $urandom;
    in_triggered = with_valid;
    @(negedge clk);
    arm          = 1'b0;
    in_valid     = 1'b0;
    in_triggered = 1'b0;
    hist.delete();
    trig_idx  = -1;
    m_armed   = 1'b1;
    m_tsample = 8'h00;
    m_post    = (post > D - 1) ? D - 1 : post;
    m_pre     = (pre > D - 1 - m_post) ? D - 1 - m_post : pre;
    check_status("arm");
  endtask

  task automatic feed(input logic [DW-1:0] data, input bit trig, input logic [7:0] ts);
    in_valid       = 1'b1;
    in_data        = data;
    in_triggered   = trig;
    in_trig_sample = ts;
    @(negedge clk);
    in_valid     = 1'b0;
    in_triggered = 1'b0;
    if (m_armed && !m_done()) begin
      if (trig && trig_idx < 0 && hist.size() >= m_pre) begin
        trig_idx  = hist.size();
        m_tsample = ts;
      end
      hist.push_back(data);
    end
    check_status("feed");
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic read_window(input int mode);
    int            len;
    int            s;
    int            idx;
    int            cyc;
    bit            stalled;
    bit            r;
    logic [DW-1:0] held;
    len     = m_pre + 1 + m_post;
    s       = trig_idx - m_pre;
    idx     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    check("capt_len", 64'(capt_len), 64'(len));
    rd_start = 1'b1;
    rd_ready = 1'b0;
    @(negedge clk);
    rd_start = 1'b0;
    check("rd first latency", 64'(rd_valid), 64'd1);
    while (idx < len && cyc < 200) begin
      if (stalled) begin
        check("stall valid", 64'(rd_valid), 64'd1);
        check("stall data", 64'(rd_data), 64'(held));
      end
      if (mode == 0) check("no bubble", 64'(rd_valid), 64'd1);
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rd_ready = r;
      if (rd_valid && r) begin
        check("rd_data", 64'(rd_data), 64'(hist[s + idx]));
        check("rd_last", 64'(rd_last), 64'(idx == len - 1));
        idx++;
        stalled = 1'b0;
      end else if (rd_valid) begin
        stalled = 1'b1;
        held    = rd_data;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    check("xfer count", 64'(idx), 64'(len));
    check("post-read valid", 64'(rd_valid), 64'd0);
    check("post-read state", 64'(state), 64'd4);
    check("post-read done", 64'(done), 64'd1);
  endtask

  initial begin
    int guard;
    rst = 1'b1; arm = 1'b0; pre_words = '0; post_words = '0;
    in_valid = 1'b0; in_data = '0; in_triggered = 1'b0; in_trig_sample = '0;
    rd_start = 1'b0; rd_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_status("reset");
    check("reset rd_valid", 64'(rd_valid), 64'd0);
    check("reset capt_len", 64'(capt_len), 64'd0);
    check("reset rd_last", 64'(rd_last), 64'd0);
    check("reset rd_data", 64'(rd_data), 64'd0);

    // Basic window: pre=3 post=2, trigger on word 5
    do_arm(3, 2, 1'b0);
    for (int i = 0; i < 10; i++) feed(DW'(i), (i == 5), 8'hA5);
    check("t1 trig_addr", 64'(trig_addr), 64'd5);
    check("t1 capt_len", 64'(capt_len), 64'd6);
    read_window(0);

    // Trigger during pre-trigger fill is ignored
    do_arm(3, 2, 1'b0);
    for (int i = 0; i < 12; i++)
      feed(DW'(100 + i), (i == 1) || (i == 6), (i == 1) ? 8'h11 : 8'h66);
    check("t2 trig_addr", 64'(trig_addr), 64'd6);
    check("t2 trig_sample", 64'(trig_sample_out), 64'h66);
    read_window(2);

    // Full-depth window with wrap; rd_start outside DONE is ignored
    do_arm(15, 15, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("rd_start ignored state", 64'(state), 64'd2);
        check("rd_start ignored valid", 64'(rd_valid), 64'd0);
      end
      feed($urandom, (i == 20), 8'h20);
    end
    check("t3 trig_addr", 64'(trig_addr), 64'd4);
    check("t3 capt_len", 64'(capt_len), 64'd16);
    read_window(1);
    read_window(0);

    // arm wins over a coincident word
    do_arm(2, 1, 1'b1);
    for (int i = 0; i < 5; i++) feed($urandom, (i == 2), 8'h5A);
    read_window(0);

    // Word count, then reset in POSTTRIG
    do_arm(5, 5, 1'b0);
    for (int i = 0; i < 12; i++) feed($urandom, 1'b0, 8'h00);
`ifdef CAPTURE_WORD_CNT_EN
    check("word_cnt 12", 64'(word_cnt), 64'd12);
`else
    check("word_cnt off", 64'(word_cnt), 64'd0);
`endif
    feed($urandom, 1'b1, 8'h77);
    feed($urandom, 1'b0, 8'h00);
    check("pre-rst state", 64'(state), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_status("rst posttrig");
    check("rst posttrig valid", 64'(rd_valid), 64'd0);
    feed($urandom, 1'b1, 8'h01);

    // Reset in READ
    do_arm(4, 4, 1'b0);
    guard = 0;
    while (!m_done() && guard < 40) begin
      feed($urandom, (guard == 6), 8'h42);
      guard++;
    end
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_ready = 1'b0;
    model_reset();
    check_status("rst read");
    check("rst read valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    check("rst read valid later", 64'(rd_valid), 64'd0);

    // Randomized captures
    for (int k = 0; k < 6; k++) begin
      do_arm(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 30; i++)
        feed($urandom, ($urandom_range(0, 5) == 0), 8'($urandom));
      guard = 0;
      while (!m_done() && guard < 40) begin
        feed($urandom, 1'b1, 8'($urandom));
        guard++;
      end
      check("rand done", 64'(done), 64'd1);
      read_window(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
